// File: rtl/seg_sched_pkg.sv
// Shared encodings and helpers for the 7-segment display scheduler.
package seg_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_ALARM = 2'd2
    } state_t;

    localparam logic [1:0] SRC_ALARM = 2'd2;
    localparam logic [1:0] SRC_NONE  = 2'd3;

    // Clamp a 20-bit magnitude so the driver's BCD conversion stays in 0..9 per digit.
    function automatic logic [19:0] sat_data(input logic [19:0] v, input logic [19:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/seg_ms_tick.sv
// Free-running 1 ms prescaler; tick_1ms is high for the single cycle where the count is at its top.
module seg_ms_tick #(
    parameter int CNT_1MS_MAX = 49_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic tick_1ms
);

    localparam int              CW       = $clog2(CNT_1MS_MAX + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_1MS_MAX);

    logic [CW-1:0] cnt;

    assign tick_1ms = (cnt == CNT_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (tick_1ms) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seg_disp_sched.sv
// Shares one 6-digit 7-segment driver between two rotating normal sources and a
// pre-empting, blinking alarm source. All outputs are registered.
module seg_disp_sched
    import seg_sched_pkg::*;
#(
    parameter int          CNT_1MS_MAX = 49_999,
    parameter int          DWELL_MS    = 2000,
    parameter int          BLINK_MS    = 250,
    parameter logic [19:0] DATA_MAX    = 20'd999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [2:0]  src_vld,
    input  logic [19:0] src0_data,
    input  logic [5:0]  src0_point,
    input  logic        src0_sign,
    input  logic [19:0] src1_data,
    input  logic [5:0]  src1_point,
    input  logic        src1_sign,
    input  logic [19:0] src2_data,
    input  logic [5:0]  src2_point,
    input  logic        src2_sign,
    input  logic        hold_tgl,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en,
    output logic [1:0]  cur_src,
    output logic [2:0]  src_ack
);

    localparam int            DW         = $clog2(DWELL_MS + 1);
    localparam int            BW         = $clog2(BLINK_MS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_MS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

    logic tick_1ms;

    state_t        state, state_nx;
    logic          sel, sel_nx;              // normal source shown while in SHOW
    logic [DW-1:0] dwell, dwell_nx;
    logic [BW-1:0] blink, blink_nx;
    logic          blink_on, blink_on_nx;
    logic          hold, hold_nx;
    logic [1:0]    ret_src, ret_src_nx;
    logic          other_vld, ret_ok;

    logic [19:0]   data_nx;
    logic [5:0]    point_nx;
    logic          sign_nx, seg_en_nx;
    logic [1:0]    cur_src_nx;
    logic [2:0]    src_ack_nx;

    seg_ms_tick #(
        .CNT_1MS_MAX(CNT_1MS_MAX)
    ) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .tick_1ms(tick_1ms)
    );

    // src_vld is a level request per source; src_ack pulses for one cycle when
    // cur_src first switches to that source. There is no back-pressure.
    always_comb begin
        state_nx    = state;
        sel_nx      = sel;
        dwell_nx    = dwell;
        blink_nx    = blink;
        blink_on_nx = blink_on;
        hold_nx     = hold;
        ret_src_nx  = ret_src;
        other_vld   = sel ? src_vld[0] : src_vld[1];
        ret_ok      = (ret_src != SRC_NONE) && src_vld[ret_src[0]];

        if (src_vld[2] && (state != S_ALARM)) begin
            // Alarm entry outranks rotation, loss of request and hold_tgl.
            state_nx    = S_ALARM;
            ret_src_nx  = (state == S_SHOW) ? {1'b0, sel} : SRC_NONE;
            blink_nx    = '0;
            blink_on_nx = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (src_vld[0]) begin
                        state_nx = S_SHOW;
                        sel_nx   = 1'b0;
                        dwell_nx = '0;
                    end else if (src_vld[1]) begin
                        state_nx = S_SHOW;
                        sel_nx   = 1'b1;
                        dwell_nx = '0;
                    end
                end
                S_SHOW: begin
                    if (hold_tgl) hold_nx = ~hold;
                    if (!src_vld[sel]) begin
                        dwell_nx = '0;
                        if (other_vld) sel_nx = ~sel;
                        else           state_nx = S_IDLE;
                    end else if (tick_1ms && !hold) begin
                        if (dwell == DWELL_LAST) begin
                            dwell_nx = '0;
                            if (other_vld) sel_nx = ~sel;
                        end else begin
                            dwell_nx = dwell + DW'(1);
                        end
                    end
                end
                S_ALARM: begin
                    if (hold_tgl) hold_nx = ~hold;
                    if (!src_vld[2]) begin
                        dwell_nx = '0;
                        state_nx = S_SHOW;
                        if (ret_ok)          sel_nx = ret_src[0];
                        else if (src_vld[0]) sel_nx = 1'b0;
                        else if (src_vld[1]) sel_nx = 1'b1;
                        else                 state_nx = S_IDLE;
                    end else if (tick_1ms) begin
                        if (blink == BLINK_LAST) begin
                            blink_nx    = '0;
                            blink_on_nx = ~blink_on;
                        end else begin
                            blink_nx = blink + BW'(1);
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end

        if (state_nx == S_IDLE) begin
            hold_nx  = 1'b0;
            dwell_nx = '0;
        end
    end

    // Output values are derived from the next state so they land with it.
    always_comb begin
        data_nx    = '0;
        point_nx   = '0;
        sign_nx    = 1'b0;
        seg_en_nx  = 1'b0;
        cur_src_nx = SRC_NONE;
        case (state_nx)
            S_SHOW: begin
                data_nx    = sat_data(sel_nx ? src1_data : src0_data, DATA_MAX);
                point_nx   = sel_nx ? src1_point : src0_point;
                sign_nx    = sel_nx ? src1_sign : src0_sign;
                seg_en_nx  = 1'b1;
                cur_src_nx = {1'b0, sel_nx};
            end
            S_ALARM: begin
                data_nx    = sat_data(src2_data, DATA_MAX);
                point_nx   = src2_point;
                sign_nx    = src2_sign;
                seg_en_nx  = blink_on_nx;
                cur_src_nx = SRC_ALARM;
            end
            default: ;
        endcase
        // Shifting by SRC_NONE (3) yields zero, so "none" never acks.
        src_ack_nx = (cur_src_nx != cur_src) ? (3'b001 << cur_src_nx) : 3'b000;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            sel      <= 1'b0;
            dwell    <= '0;
            blink    <= '0;
            blink_on <= 1'b0;
            hold     <= 1'b0;
            ret_src  <= SRC_NONE;
            data     <= '0;
            point    <= '0;
            sign     <= 1'b0;
            seg_en   <= 1'b0;
            cur_src  <= SRC_NONE;
            src_ack  <= '0;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            dwell    <= dwell_nx;
            blink    <= blink_nx;
            blink_on <= blink_on_nx;
            hold     <= hold_nx;
            ret_src  <= ret_src_nx;
            data     <= data_nx;
            point    <= point_nx;
            sign     <= sign_nx;
            seg_en   <= seg_en_nx;
            cur_src  <= cur_src_nx;
            src_ack  <= src_ack_nx;
        end
    end

endmodule

// File: tb/tb_seg_disp_sched.sv
// Randomised and directed stimulus for seg_disp_sched, checked cycle by cycle
// against a source-level reference model through an expected-value queue.
module tb_seg_disp_sched;

    localparam int CNT  = 9;
    localparam int DWELL = 3;
    localparam int BLINK = 2;
    localparam int EW   = 33;

    typedef struct packed {
        logic [19:0] data;
        logic [5:0]  point;
        logic        sign;
        logic        seg_en;
        logic [1:0]  cur_src;
        logic [2:0]  ack;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [2:0]  src_vld = '0;
    logic [19:0] d [3];
    logic [5:0]  p [3];
    logic        s [3];
    logic        hold_tgl = 1'b0;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign, seg_en;
    logic [1:0]  cur_src;
    logic [2:0]  src_ack;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];

    // reference model: which source is on screen and its timers, in ms units
    int shown, ret, ms_phase, dwell_ms, blink_ms;
    bit lit, hold;

    seg_disp_sched #(
        .CNT_1MS_MAX(CNT),
        .DWELL_MS   (DWELL),
        .BLINK_MS   (BLINK)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .src_vld   (src_vld),
        .src0_data (d[0]),
        .src0_point(p[0]),
        .src0_sign (s[0]),
        .src1_data (d[1]),
        .src1_point(p[1]),
        .src1_sign (s[1]),
        .src2_data (d[2]),
        .src2_point(p[2]),
        .src2_sign (s[2]),
        .hold_tgl  (hold_tgl),
        .data      (data),
        .point     (point),
        .sign      (sign),
        .seg_en    (seg_en),
        .cur_src   (cur_src),
        .src_ack   (src_ack)
    );

    // clock / reset
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    function automatic logic [19:0] clamp(input logic [19:0] v);
        return (v > 20'd999_999) ? 20'd999_999 : v;
    endfunction

    task automatic model_reset();
        shown = -1; ret = -1; ms_phase = 0; dwell_ms = 0; blink_ms = 0;
        lit = 1'b0; hold = 1'b0;
    endtask

    // One clock edge of the reference model with the inputs currently applied.
    task automatic model_step();
        exp_t e;
        int   prev, other;
        bit   tick, old_hold;
        e = '0;
        e.cur_src = 2'd3;
        if (sys_rst) begin
            model_reset();
            exp_q.push_back(e);
            return;
        end
        tick = (ms_phase == CNT);
        ms_phase = tick ? 0 : ms_phase + 1;
        prev = shown;
        old_hold = hold;
        if (src_vld[2]) begin
            if (shown != 2) begin
                ret = shown; blink_ms = 0; lit = 1'b1; shown = 2;
            end else begin
                if (hold_tgl) hold = !hold;
                if (tick) begin
                    blink_ms++;
                    if (blink_ms == BLINK) begin blink_ms = 0; lit = !lit; end
                end
            end
        end else if (shown == 2) begin
            if (hold_tgl) hold = !hold;
            dwell_ms = 0;
            if (ret >= 0 && src_vld[ret]) shown = ret;
            else if (src_vld[0]) shown = 0;
            else if (src_vld[1]) shown = 1;
            else shown = -1;
        end else if (shown == -1) begin
            dwell_ms = 0;
            shown = src_vld[0] ? 0 : (src_vld[1] ? 1 : -1);
        end else begin
            if (hold_tgl) hold = !hold;
            other = 1 - shown;
            if (!src_vld[shown]) begin
                dwell_ms = 0;
                shown = src_vld[other] ? other : -1;
            end else if (tick && !old_hold) begin
                dwell_ms++;
                if (dwell_ms == DWELL) begin
                    dwell_ms = 0;
                    if (src_vld[other]) shown = other;
                end
            end
        end
        if (shown == -1) begin hold = 1'b0; dwell_ms = 0; end
        if (shown >= 0) begin
            e.data    = clamp(d[shown]);
            e.point   = p[shown];
            e.sign    = s[shown];
            e.seg_en  = (shown == 2) ? lit : 1'b1;
            e.cur_src = shown[1:0];
            if (shown != prev) e.ack = 3'(1 << shown);
        end
        exp_q.push_back(e);
    endtask

    // driver: inputs are applied at the falling edge, then the model predicts the next rising edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(negedge sys_clk);
            hold_tgl = 1'b0;
        end
    endtask

    task automatic pulse_hold();
        hold_tgl = 1'b1;
        step(1);
    endtask

    function automatic logic [19:0] rand_data();
        case ($urandom_range(0, 7))
            0: return 20'd999_999;
            1: return 20'd1_000_000;
            2: return 20'hFFFFF;
            3: return 20'd0;
            default: return 20'($urandom_range(0, 20'hFFFFF));
        endcase
    endfunction

    // scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("data",    data,           e.data);
                check("point",   20'(point),     20'(e.point));
                check("sign",    20'(sign),      20'(e.sign));
                check("seg_en",  20'(seg_en),    20'(e.seg_en));
                check("cur_src", 20'(cur_src),   20'(e.cur_src));
                check("src_ack", 20'(src_ack),   20'(e.ack));
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin d[i] = '0; p[i] = '0; s[i] = 1'b0; end
        model_reset();
        #22;
        check("rst_data",    data,         20'd0);
        check("rst_seg_en",  20'(seg_en),  20'd0);
        check("rst_cur_src", 20'(cur_src), 20'd3);
        check("rst_ack",     20'(src_ack), 20'd0);
        check("rst_point",   20'(point),   20'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        step(4);

        // single source comes up
        d[0] = 20'd12345; p[0] = 6'b000100;
        src_vld = 3'b001;
        step(10);
        // two sources rotate
        d[1] = 20'd678; p[1] = 6'b000010; s[1] = 1'b1;
        src_vld = 3'b011;
        step(100);
        // alarm pre-empts, blinks, then releases
        d[2] = 20'd999;
        src_vld = 3'b111;
        step(65);
        src_vld = 3'b011;
        step(40);
        // saturation boundaries
        src_vld = 3'b001;
        d[0] = 20'hFFFFF;      step(3);
        d[0] = 20'd999_999;    step(3);
        d[0] = 20'd1_000_000;  step(3);
        d[0] = 20'd0;          step(3);
        // hold freezes rotation, second toggle resumes it
        src_vld = 3'b011;
        step(7);
        pulse_hold();
        step(100);
        pulse_hold();
        step(45);
        // hold survives an alarm
        pulse_hold();
        src_vld = 3'b111;
        step(30);
        pulse_hold();
        step(5);
        src_vld = 3'b011;
        step(50);
        // reset in the middle of an alarm
        src_vld = 3'b111;
        step(15);
        sys_rst = 1'b1;
        step(3);
        sys_rst = 1'b0;
        step(20);
        // everything goes away
        src_vld = 3'b000;
        step(10);

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0) src_vld[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) src_vld[2] = ~src_vld[2];
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    d[k] = rand_data();
                    p[k] = 6'($urandom_range(0, 63));
                    s[k] = 1'($urandom_range(0, 1));
                end
            end
            hold_tgl = ($urandom_range(0, 49) == 0);
            sys_rst  = ($urandom_range(0, 1499) == 0);
            step(1);
        end
        sys_rst = 1'b0;
        step(2);

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge sys_clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_disp_sched.md
Name: seg_disp_sched

Overview:
Display scheduler that shares the single 6-digit dynamic 7-segment display driver between three requesters: two normal sources and one alarm source.
It time-multiplexes the two normal sources on a millisecond dwell timer. The alarm source pre-empts both and is shown blinking.
Its outputs drive the display driver's data/point/sign/seg_en inputs directly.
Values are saturated so the driver's BCD conversion never sees a value above 999_999.

Parameters:
CNT_1MS_MAX, 49_999, sys_clk cycles per 1 ms tick minus 1 (50 MHz clock)
DWELL_MS, 2000, ms each normal source stays on display before rotating
BLINK_MS, 250, ms per blink half-period in ALARM
DATA_MAX, 999_999, saturation limit for displayed magnitude

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  reset, asynchronous, active-high
src_vld  in  3  per-source request level; bit 2 = alarm source
src0_data  in  20  source 0 magnitude
src0_point  in  6  source 0 decimal points, high = lit
src0_sign  in  1  source 0 minus sign
src1_data / src1_point / src1_sign  in  20/6/1  source 1 fields
src2_data / src2_point / src2_sign  in  20/6/1  alarm source fields
hold_tgl  in  1  single-cycle pulse; toggles rotation freeze
data  out  20  value to display driver
point  out  6  decimal points to display driver
sign  out  1  sign to display driver
seg_en  out  1  display enable to display driver
cur_src  out  2  displayed source: 0, 1, 2; 3 = none
src_ack  out  3  one-cycle pulse on the bit of a source when it becomes displayed

Behaviour:
- Reset (async, sys_rst=1):
  - state IDLE; data=0, point=0, sign=0, seg_en=0, cur_src=3, src_ack=0.
  - hold=0; all counters 0.
- Tick generation:
  - tick_1ms pulses for one cycle when cnt reaches CNT_1MS_MAX, then cnt wraps to 0.
  - cnt free-runs and is never cleared by state changes.
- States: IDLE, SHOW, ALARM.
- IDLE:
  - seg_en=0, data=0, cur_src=3.
  - On src_vld[2]=1, go to ALARM. Otherwise on src_vld[0] go to SHOW(src0). Otherwise on src_vld[1] go to SHOW(src1).
  - If src_vld[1:0] rise together, src0 wins.
- SHOW:
  - Outputs follow the selected source's fields every cycle, registered, 1-cycle latency; seg_en=1.
  - dwell counter increments on tick_1ms while hold=0. At DWELL_MS-1 with tick_1ms, rotate to the other normal source if it is valid; otherwise stay, restart dwell, and issue no ack.
  - If the selected source drops vld, switch next cycle to the other valid normal source, else go to IDLE.
  - hold=1 freezes dwell at its current value.
- ALARM:
  - Entered from any state the cycle after src_vld[2]=1. Alarm priority beats rotation, loss of vld and hold_tgl in the same cycle.
  - Save the return source (0, 1 or none); clear the blink counter; seg_en=1 in the first half-period.
  - seg_en toggles every BLINK_MS ticks. data/point/sign follow src2 continuously.
  - Exit the cycle after src_vld[2]=0. Return to the saved source if still valid, else the other valid normal source, else IDLE. dwell restarts from 0.
- hold:
  - Toggled by hold_tgl in SHOW and ALARM; the value is kept through ALARM.
  - hold_tgl is ignored in IDLE.
  - hold is forced to 0 on entry to IDLE.
- src_ack: one-cycle pulse on the source's bit in the first cycle it is displayed, i.e. the cycle cur_src changes to it. No pulse on a dwell restart that keeps the same source.
- Saturation:
  - data = min(src_data, DATA_MAX), using an unsigned 20-bit compare.
  - point and sign pass through unchanged.
  - This prevents the hundred-thousands BCD digit reaching 10 or more for inputs 1_000_000 to 1_048_575.
- Reset mid-operation: all registers return to reset values immediately; no ack is issued.

Decomposition:
- Shared package/include seg_sched_pkg:
  - state encodings S_IDLE=2'd0, S_SHOW=2'd1, S_ALARM=2'd2
  - SRC_NONE=2'd3
  - SRC_ALARM=2'd2
- One natural sub-module: seg_ms_tick. It holds the 1 ms prescaler, parameter CNT_1MS_MAX, and has outputs tick_1ms. Everything else stays in seg_disp_sched.

Test Plan:
Bench parameters for all scenarios: CNT_1MS_MAX=9, DWELL_MS=3, BLINK_MS=2.
1. Reset, then src_vld=3'b001 with src0_data=12345, point=6'b000100 -> one cycle later data=12345, point=000100, seg_en=1, cur_src=0, src_ack=001 for one cycle.
2. src_vld=3'b011, src1_data=678 -> cur_src alternates 0,1,0 every 30 clk. Each change gives an ack pulse on the matching bit.
3. In SHOW(src0), assert src_vld[2] with src2_data=999 -> cur_src=2 one cycle later, src_ack=100. seg_en toggles every 20 clk. Dropping src_vld[2] returns cur_src=0 with dwell restarted.
4. src0_data=20'hFFFFF -> data=999_999; src0_data=999_999 -> data=999_999; src0_data=0 -> data=0.
5. hold_tgl pulse in SHOW with both sources valid -> no rotation for 100 clk. A second hold_tgl pulse -> rotation resumes after 30 clk from the resume point.
6. Assert sys_rst mid-ALARM, and separately clear all src_vld -> all outputs return to reset values: seg_en=0, cur_src=3, data=0. No ack is issued.
